exec_unit: RTL
==============

# exec_unit

Parametrised execute stage: register file, operand muxes, ALU and an optional iterative unsigned multiply/divide sequencer, with a registered valid/ready output stage. Successor to the single-cycle register-file-plus-ALU datapath. Sits between decode and memory in the pipelined RISC-V core. Writeback arrives on a dedicated port, with a same-cycle read bypass.

## Interface
- A_WIDTH, 5: register address width; register count = 2**A_WIDTH.
- D_WIDTH, 32: datapath width; must be a power of two, at least 8.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1 / 1  issue handshake; an op transfers when both are high.
- ALUControl  in  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10–15 produce 0.
- ALUSrc, PCUppSrc  in  1 each  SrcB = ImmExt when ALUSrc is high, else RD2. SrcA = PC when PCUppSrc is high, else RD1.
- MulDiv  in  1  route the op to the sequencer.
- MulOp  in  2  0 MUL (low half), 1 MULHU, 2 DIVU, 3 REMU.
- A1, A2, A3  in  A_WIDTH  source and destination addresses.
- RegWrite  in  1  destination write enable, carried with the op.
- PC, ImmExt  in  D_WIDTH each  operands.
- WB_WE, WB_A, WB_D  in  1 / A_WIDTH / D_WIDTH  writeback port.
- out_valid / out_ready  out / in  1 / 1  result handshake.
- ALUResult, RD2_out  out  D_WIDTH each  registered result and store data.
- A3_out, RegWrite_out  out  A_WIDTH / 1  registered destination info.
- Zero  out  1  registered flag, ALUResult == 0.
- a0  out  D_WIDTH  live value of x10.

## Operation
- Register file:
  - x0 reads 0; writes to x0 are dropped.
  - Write on the clock edge when WB_WE is high.
  - Read bypass: when WB_WE is high and WB_A == A1 (or A2) and the address is nonzero, the read returns WB_D in the same cycle.
- ALU:
  - Shift amount = SrcB[$clog2(D_WIDTH)-1:0].
  - SRA is arithmetic. SLT is signed; SLTU is unsigned.
  - Add and sub wrap modulo 2**D_WIDTH.
- Sequencer FSM, states IDLE, BUSY and HOLD:
  - IDLE → BUSY on an accepted op with MulDiv high. The sequencer latches SrcA and SrcB, and the counter is loaded with D_WIDTH.
  - BUSY runs one shift-add (MUL/MULHU) or one restoring-divide step per cycle and decrements the counter. At counter 0 it loads the output register and moves to HOLD.
  - HOLD → IDLE once the output register is free, i.e. out_valid is low or out_ready is high.
- Divide by zero: DIVU returns all-ones; REMU returns the dividend.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- The output register holds its values while out_valid is high and out_ready is low.
- Reset mid-operation: the sequencer aborts to IDLE and all registers clear.

## Timing
- Reset values: out_valid 0, ALUResult 0, RD2_out 0, A3_out 0, RegWrite_out 0, Zero 0, all registers 0, a0 0.
- ALU op: result is visible with out_valid high on the cycle after acceptance, i.e. latency 1. Throughput is one op per cycle while out_ready is high.
- Mul/div op:
  - in_ready drops the cycle after acceptance.
  - out_valid rises D_WIDTH+1 cycles after acceptance.
  - in_ready returns the cycle out_valid rises, provided out_ready is high.
- Simultaneous events:
  - Writeback and read of the same register in one cycle: the bypass applies.
  - Output pop and ALU accept in one cycle: the output register loads the new op with no bubble.

## Configuration
- Macro EXEC_MULDIV_EN.
- Defined: the sequencer and MulDiv/MulOp behaviour are as above.
- Undefined: the sequencer is not instantiated and MulDiv/MulOp are ignored. Every op executes as an ALU op with latency 1, and in_ready = !out_valid || out_ready.

## Structure
- Package exec_pkg holds:
  - alu_op_e, a 4-bit enum of the ALU encodings above;
  - muldiv_op_e, a 2-bit enum;
  - seq_state_e, with IDLE, BUSY and HOLD;
  - the ALU_NOP constant.
- One sub-module, muldiv_seq. It owns the FSM, the counter and the accumulator/remainder registers. It handshakes with exec_unit via start, busy and done, and presents its result to exec_unit's output stage.

## Test plan
- Reset, WB writes x10 = 0x1234, then ADD x11 = x10 + imm 4: a0 == 0x1234; one cycle after acceptance ALUResult == 0x1238, Zero 0.
- WB write x5 = 7 in the same cycle as SUB with A1 = x5, A2 = x5: the bypass applies, ALUResult 0 and Zero 1. A write to x0 with 0xFF, then a read of x0: returns 0.
- SRA of 0x80000000 by 4 gives 0xF8000000. SLTU(1, 0xFFFFFFFF) gives 1; SLT(1, 0xFFFFFFFF) gives 0.
- EXEC_MULDIV_EN defined:
  - MULHU(0xFFFFFFFF, 2) gives 1 after 33 cycles, with in_ready low throughout.
  - DIVU(100, 7) gives 14; REMU(100, 7) gives 2.
  - DIVU(5, 0) gives 0xFFFFFFFF; REMU(5, 0) gives 5.
- out_ready held low for 3 cycles: ALUResult stable, in_ready low. Release out_ready: the next ALU op issues the same cycle with no bubble.
- RST_N asserted mid-division at cycle 10: out_valid 0 and state IDLE immediately. After release, in_ready is 1 and a new ADD completes normally.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execute stage.
//   alu_op_e    - 4-bit ALU operation encoding (10..15 produce 0)
//   muldiv_op_e - 2-bit multiply/divide operation encoding
//   seq_state_e - multiply/divide sequencer states
//   ALU_NOP     - an ALU encoding that always yields 0
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  localparam logic [3:0] ALU_NOP = 4'hF;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply / divide sequencer.
//   One shift-add (MUL/MULHU) or restoring-divide (DIVU/REMU) step per cycle,
//   D_WIDTH steps per op.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - accept a new op (only honoured in IDLE)
//   take        - the consumer's output register is free this cycle
//   op          - muldiv_op_e
//   srca, srcb  - operands (multiplier/multiplicand, dividend/divisor)
//   busy        - sequencer is not IDLE
//   done        - result is valid and waiting to be taken
//   result      - selected half of the product / quotient / remainder
module muldiv_seq
  import exec_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               take,
  input  muldiv_op_e         op,
  input  logic [D_WIDTH-1:0] srca,
  input  logic [D_WIDTH-1:0] srcb,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] result
);

  localparam int CW = $clog2(D_WIDTH) + 1;

  seq_state_e         state, state_nx;
  muldiv_op_e         op_q;
  logic [CW-1:0]      cnt;
  logic [D_WIDTH-1:0] hi;   // product high half / partial remainder
  logic [D_WIDTH-1:0] lo;   // multiplier -> product low half / dividend -> quotient
  logic [D_WIDTH-1:0] opb;  // multiplicand / divisor

  logic               last;
  logic [D_WIDTH:0]   mul_sum;
  logic [D_WIDTH:0]   div_sh;
  logic               div_ge;
  logic [D_WIDTH-1:0] div_diff;

  assign last = (state == BUSY) && (cnt == '0);
  assign busy = (state != IDLE);
  assign done = last || (state == HOLD);

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_sh   = {hi, lo[D_WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opb});
    // When div_ge holds the true difference fits in D_WIDTH bits.
    div_diff = div_sh[D_WIDTH-1:0] - opb;
  end

  always_comb begin
    unique case (op_q)
      MD_MUL, MD_DIVU: result = lo;
      default:         result = hi;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The final step leaves straight for IDLE when the result is taken on the
  // same edge, so in_ready can return in the cycle out_valid rises; HOLD
  // only parks a result the output stage cannot yet accept.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = BUSY;
      BUSY: if (cnt == '0) state_nx = take ? IDLE : HOLD;
      HOLD: if (take) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= MD_MUL;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      opb  <= '0;
    end else begin
      if (state == IDLE) begin
        if (start) begin
          op_q <= op;
          cnt  <= CW'(D_WIDTH);
          hi   <= '0;
          lo   <= srca;
          opb  <= srcb;
        end
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (op_q == MD_DIVU || op_q == MD_REMU) begin
          hi <= div_ge ? div_diff : div_sh[D_WIDTH-1:0];
          lo <= {lo[D_WIDTH-2:0], div_ge};
        end else begin
          hi <= mul_sum[D_WIDTH:1];
          lo <= {mul_sum[0], lo[D_WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage - register file with writeback bypass, operand
// muxes, ALU, optional multiply/divide sequencer and a registered
// valid/ready output stage.
// Configuration macro: EXEC_MULDIV_EN (defined: muldiv_seq instantiated and
//   MulDiv/MulOp honoured; undefined: every op is a latency-1 ALU op).
// Ports:
//   CLK, RST_N            - clock, asynchronous active-low reset
//   in_valid/in_ready     - issue handshake
//   ALUControl, ALUSrc, PCUppSrc, MulDiv, MulOp - operation controls
//   A1, A2, A3, RegWrite  - source/destination addresses, write enable
//   PC, ImmExt            - operands
//   WB_WE, WB_A, WB_D     - writeback port
//   out_valid/out_ready   - result handshake
//   ALUResult, RD2_out, A3_out, RegWrite_out, Zero - registered results
//   a0                    - live value of x10
module exec_unit
  import exec_pkg::*;
#(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUControl,
  input  logic               ALUSrc,
  input  logic               PCUppSrc,
  input  logic               MulDiv,
  input  logic [1:0]         MulOp,
  input  logic [A_WIDTH-1:0] A1,
  input  logic [A_WIDTH-1:0] A2,
  input  logic [A_WIDTH-1:0] A3,
  input  logic               RegWrite,
  input  logic [D_WIDTH-1:0] PC,
  input  logic [D_WIDTH-1:0] ImmExt,
  input  logic               WB_WE,
  input  logic [A_WIDTH-1:0] WB_A,
  input  logic [D_WIDTH-1:0] WB_D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] ALUResult,
  output logic [D_WIDTH-1:0] RD2_out,
  output logic [A_WIDTH-1:0] A3_out,
  output logic               RegWrite_out,
  output logic               Zero,
  output logic [D_WIDTH-1:0] a0
);

  localparam int unsigned        NREG = 2 ** A_WIDTH;
  localparam int                 SHW  = $clog2(D_WIDTH);
  localparam logic [A_WIDTH-1:0] X10  = A_WIDTH'(10);

  logic [D_WIDTH-1:0] regs [NREG];
  logic [D_WIDTH-1:0] rd1, rd2, srca, srcb, alu_res;
  logic [SHW-1:0]     shamt;
  logic               out_free;

  logic               ld;
  logic [D_WIDTH-1:0] ld_res, ld_rd2;
  logic [A_WIDTH-1:0] ld_a3;
  logic               ld_rw;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WB_WE && WB_A != '0) begin
      regs[WB_A] <= WB_D;
    end
  end

  always_comb begin
    rd1 = regs[A1];
    if (A1 == '0)                rd1 = '0;
    else if (WB_WE && WB_A == A1) rd1 = WB_D;
  end

  always_comb begin
    rd2 = regs[A2];
    if (A2 == '0)                rd2 = '0;
    else if (WB_WE && WB_A == A2) rd2 = WB_D;
  end

  assign a0    = regs[X10];
  assign srca  = PCUppSrc ? PC : rd1;
  assign srcb  = ALUSrc ? ImmExt : rd2;
  assign shamt = srcb[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD:  alu_res = srca + srcb;
      ALU_SUB:  alu_res = srca - srcb;
      ALU_AND:  alu_res = srca & srcb;
      ALU_OR:   alu_res = srca | srcb;
      ALU_XOR:  alu_res = srca ^ srcb;
      ALU_SLT:  alu_res = D_WIDTH'($signed(srca) < $signed(srcb));
      ALU_SLTU: alu_res = D_WIDTH'(srca < srcb);
      ALU_SLL:  alu_res = srca << shamt;
      ALU_SRL:  alu_res = srca >> shamt;
      ALU_SRA:  alu_res = D_WIDTH'($signed(srca) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  assign out_free = !out_valid || out_ready;

`ifdef EXEC_MULDIV_EN
  logic               seq_start, seq_busy, seq_done, seq_ack, alu_accept;
  logic [D_WIDTH-1:0] seq_res;
  logic [D_WIDTH-1:0] pend_rd2;
  logic [A_WIDTH-1:0] pend_a3;
  logic               pend_rw;

  assign in_ready   = !seq_busy && out_free;
  assign seq_start  = in_valid && in_ready && MulDiv;
  assign alu_accept = in_valid && in_ready && !MulDiv;
  assign seq_ack    = seq_done && out_free;

  muldiv_seq #(
    .D_WIDTH(D_WIDTH)
  ) u_seq (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (seq_start),
    .take  (out_free),
    .op    (muldiv_op_e'(MulOp)),
    .srca  (srca),
    .srcb  (srcb),
    .busy  (seq_busy),
    .done  (seq_done),
    .result(seq_res)
  );

  // Destination info and store data travel alongside the sequencer op.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_rd2 <= '0;
      pend_a3  <= '0;
      pend_rw  <= 1'b0;
    end else if (seq_start) begin
      pend_rd2 <= rd2;
      pend_a3  <= A3;
      pend_rw  <= RegWrite;
    end
  end

  always_comb begin
    ld     = seq_ack || alu_accept;
    ld_res = seq_ack ? seq_res  : alu_res;
    ld_rd2 = seq_ack ? pend_rd2 : rd2;
    ld_a3  = seq_ack ? pend_a3  : A3;
    ld_rw  = seq_ack ? pend_rw  : RegWrite;
  end
`else
  logic unused_md;

  assign unused_md = ^{MulDiv, MulOp};
  assign in_ready  = out_free;

  always_comb begin
    ld     = in_valid && in_ready;
    ld_res = alu_res;
    ld_rd2 = rd2;
    ld_a3  = A3;
    ld_rw  = RegWrite;
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid    <= 1'b0;
      ALUResult    <= '0;
      RD2_out      <= '0;
      A3_out       <= '0;
      RegWrite_out <= 1'b0;
      Zero         <= 1'b0;
    end else if (ld) begin
      out_valid    <= 1'b1;
      ALUResult    <= ld_res;
      RD2_out      <= ld_rd2;
      A3_out       <= ld_a3;
      RegWrite_out <= ld_rw;
      Zero         <= (ld_res == '0);
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule
